// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC time-pulse generator.
// Contents:
//   NUM_TP      - time pulses per memory cycle time (T01..T12)
//   tp_ring_t   - ring encoding: 1..12 = T01..T12, TP_STOPPED = no pulse
//   ctl_t       - synchronized start/stop/standby request levels
//   tp_decode() - ring value to one-hot MT01..MT12 (bit 0 = MT01)
package agc_timing_pkg;

  localparam int NUM_TP = 12;

  typedef logic [3:0] tp_ring_t;

  localparam tp_ring_t TP_STOPPED = 4'd0;
  localparam tp_ring_t TP_FIRST   = 4'd1;
  localparam tp_ring_t TP_LAST    = 4'd12;

  typedef struct packed {
    logic mstrt;
    logic strt2;
    logic mstp;
    logic sby;
  } ctl_t;

  function automatic logic [NUM_TP-1:0] tp_decode(input tp_ring_t ring);
    logic [NUM_TP-1:0] mt;
    mt = '0;
    for (int i = 0; i < NUM_TP; i++) begin
      mt[i] = (ring == tp_ring_t'(i + 1));
    end
    return mt;
  endfunction

endpackage

// File: rtl/agc_sync_edge.sv
// N-stage synchronizer for asynchronous inputs, WIDTH bits wide.
// EDGE_OUT = 0: q is the synchronized level.
// EDGE_OUT = 1: q is a one-clock rising-edge pulse per bit.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset (chain clears to 0)
//   d     - asynchronous inputs
//   q     - synchronized level or rising-edge pulse
module agc_sync_edge #(
  parameter int STAGES   = 2,
  parameter int WIDTH    = 1,
  parameter bit EDGE_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  generate
    if (EDGE_OUT) begin : g_edge
      logic [WIDTH-1:0] prev;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= chain[STAGES-1];
      end
      // Built only from flop outputs, so the pulse is glitch-free and adds
      // no extra cycle of latency beyond the synchronizer itself.
      assign q = chain[STAGES-1] & ~prev;
    end else begin : g_level
      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC time-pulse generator and start/GOJAM front end.
// Runs on SIM_CLK and samples the AGC oscillator CLOCK as data. Every
// TP_CLOCKS rising edges of CLOCK the ring advances T01..T12; MGOJAM is the
// machine restart strobe and spans whole memory cycle times.
// Ports:
//   SIM_CLK, SIM_RST_n   - simulation clock, async active-low reset
//   CLOCK                - 2.048 MHz oscillator (asynchronous data input)
//   MSTRT, STRT2         - start / restart requests (GOJAM triggers)
//   MSTP                 - hold the ring at T12 while high
//   SBY                  - standby: stop ring, force GOJAM
//   MT01..MT12           - registered one-hot time pulses
//   MGOJAM               - registered GOJAM strobe, active high
//
// ring       | meaning
// -----------+-------------------------------------------
// 0          | stopped (reset or standby), no MT high
// 1..11      | T01..T11, advances to next on wrap tick
// 12         | T12, wraps to T01 unless MSTP holds it
module agc_timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TP_CLOCKS   = 2
) (
  input  logic SIM_CLK,
  input  logic SIM_RST_n,
  input  logic CLOCK,
  input  logic MSTRT,
  input  logic STRT2,
  input  logic MSTP,
  input  logic SBY,
  output logic MT01,
  output logic MT02,
  output logic MT03,
  output logic MT04,
  output logic MT05,
  output logic MT06,
  output logic MT07,
  output logic MT08,
  output logic MT09,
  output logic MT10,
  output logic MT11,
  output logic MT12,
  output logic MGOJAM
);

  localparam int SUB_W = (TP_CLOCKS > 1) ? $clog2(TP_CLOCKS) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TP_CLOCKS - 1);

  logic              tick;
  ctl_t              ctl;
  logic              trig;
  tp_ring_t          ring, ring_nxt;
  logic [SUB_W-1:0]  sub, sub_nxt;
  logic              jam, jam_nxt;
  logic [NUM_TP-1:0] mt;

  agc_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .EDGE_OUT(1'b1)) u_clock_sync (
    .clk   (SIM_CLK),
    .rst_n (SIM_RST_n),
    .d     (CLOCK),
    .q     (tick)
  );

  agc_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(4), .EDGE_OUT(1'b0)) u_ctl_sync (
    .clk   (SIM_CLK),
    .rst_n (SIM_RST_n),
    .d     ({MSTRT, STRT2, MSTP, SBY}),
    .q     (ctl)
  );

  // Reset is the fourth trigger; it is covered by jam's reset value.
  assign trig = ctl.mstrt | ctl.strt2 | ctl.sby;

  always_comb begin
    ring_nxt = ring;
    sub_nxt  = sub;
    jam_nxt  = jam | trig;
    if (ctl.sby) begin
      ring_nxt = TP_STOPPED;
      sub_nxt  = '0;
      jam_nxt  = 1'b1;
    end else if (tick) begin
      if (sub == SUB_LAST) begin
        sub_nxt = '0;
        if (ring == TP_STOPPED) begin
          ring_nxt = TP_FIRST;
        end else if (ring == TP_LAST) begin
          // An active trigger overrides the MSTP hold.
          if (!ctl.mstp || trig) begin
            ring_nxt = TP_FIRST;
            if (!trig) jam_nxt = 1'b0;
          end
        end else begin
          ring_nxt = ring + 4'd1;
        end
      end else begin
        sub_nxt = sub + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      ring <= TP_STOPPED;
      sub  <= '0;
      jam  <= 1'b1;
      mt   <= '0;
    end else begin
      ring <= ring_nxt;
      sub  <= sub_nxt;
      jam  <= jam_nxt;
      // Decode from the next ring value so the pulses leave a flop directly.
      mt   <= tp_decode(ring_nxt);
    end
  end

  assign MT01   = mt[0];
  assign MT02   = mt[1];
  assign MT03   = mt[2];
  assign MT04   = mt[3];
  assign MT05   = mt[4];
  assign MT06   = mt[5];
  assign MT07   = mt[6];
  assign MT08   = mt[7];
  assign MT09   = mt[8];
  assign MT10   = mt[9];
  assign MT11   = mt[10];
  assign MT12   = mt[11];
  assign MGOJAM = jam;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Bench for agc_timepulse_gen. CLOCK is derived from the SIM_CLK cycle count
// (24 SIM_CLK per CLOCK period) so every transition lands on a known cycle.
// With reset released just after cycle REL_CYC, the first CLOCK rise is
// captured at REL_CYC+13 and acted on at REL_CYC+15; the second one enters
// T01 at T0 = REL_CYC+39. Each time pulse then lasts 48 cycles ("slot").
module tb_agc_timepulse_gen;

  localparam int REL_CYC = 264;
  localparam int T0      = REL_CYC + 39;
  localparam int SLOT    = 48;

  logic SIM_CLK   = 1'b0;
  logic SIM_RST_n = 1'b0;
  logic CLOCK     = 1'b0;
  logic MSTRT     = 1'b0;
  logic STRT2     = 1'b0;
  logic MSTP      = 1'b0;
  logic SBY       = 1'b0;
  logic MT01, MT02, MT03, MT04, MT05, MT06;
  logic MT07, MT08, MT09, MT10, MT11, MT12;
  logic MGOJAM;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  // ctl = {MSTRT, STRT2, MSTP, SBY}, applied right after the check.
  typedef struct {
    int         slot;
    int         ofs;
    logic [3:0] ctl;
    int         exp_tp;
    logic       exp_jam;
  } vec_t;

  vec_t vecs[$];

  agc_timepulse_gen #(.SYNC_STAGES(2), .TP_CLOCKS(2)) dut (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST_n (SIM_RST_n),
    .CLOCK     (CLOCK),
    .MSTRT     (MSTRT),
    .STRT2     (STRT2),
    .MSTP      (MSTP),
    .SBY       (SBY),
    .MT01      (MT01),
    .MT02      (MT02),
    .MT03      (MT03),
    .MT04      (MT04),
    .MT05      (MT05),
    .MT06      (MT06),
    .MT07      (MT07),
    .MT08      (MT08),
    .MT09      (MT09),
    .MT10      (MT10),
    .MT11      (MT11),
    .MT12      (MT12),
    .MGOJAM    (MGOJAM)
  );

  always #10 SIM_CLK = ~SIM_CLK;

  always @(posedge SIM_CLK) cyc <= cyc + 1;

  always @(negedge SIM_CLK) CLOCK = ((cyc % 24) >= 12);

  function automatic logic [11:0] onehot(input int tp);
    logic [11:0] one;
    one = 12'd1;
    if (tp == 0) return 12'd0;
    return one << (tp - 1);
  endfunction

  function automatic void add(input int s, input int o, input logic [3:0] c,
                              input int tp, input logic j);
    vec_t v;
    v.slot    = s;
    v.ofs     = o;
    v.ctl     = c;
    v.exp_tp  = tp;
    v.exp_jam = j;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int exp_tp, input logic exp_jam);
    logic [11:0] mt;
    mt = {MT12, MT11, MT10, MT09, MT08, MT07, MT06, MT05, MT04, MT03, MT02, MT01};
    n_tests++;
    if (mt !== onehot(exp_tp) || MGOJAM !== exp_jam) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: MT=%b MGOJAM=%b, required MT=%b MGOJAM=%b",
               name, cyc, mt, MGOJAM, onehot(exp_tp), exp_jam);
    end
  endtask

  // Returns 1 ns after the posedge that brings the cycle count to target.
  task automatic wait_cyc(input int target);
    if (cyc >= target) begin
      n_fail++;
      $display("FAIL schedule: cycle %0d already past target %0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge SIM_CLK);
      #1;
    end
  endtask

  initial begin
    int a, b, c;

    add(  0, -1, 4'b0000,  0, 1'b1);
    add(  0,  0, 4'b0000,  1, 1'b1);
    add(  0, 47, 4'b0000,  1, 1'b1);
    add(  1,  0, 4'b0000,  2, 1'b1);
    add( 11, 47, 4'b0000, 12, 1'b1);
    add( 12,  0, 4'b0000,  1, 1'b0);
    add( 23, 24, 4'b0000, 12, 1'b0);
    add( 24, 24, 4'b1000,  1, 1'b0);
    add( 24, 26, 4'b1000,  1, 1'b0);
    add( 24, 27, 4'b1000,  1, 1'b1);
    add( 29, 24, 4'b0000,  6, 1'b1);
    add( 35, 47, 4'b0000, 12, 1'b1);
    add( 36,  0, 4'b0000,  1, 1'b0);
    add( 40, 24, 4'b0010,  5, 1'b0);
    add( 47, 47, 4'b0010, 12, 1'b0);
    add( 48, 24, 4'b0010, 12, 1'b0);
    add( 51, 24, 4'b0000, 12, 1'b0);
    add( 52,  0, 4'b0000,  1, 1'b0);
    add( 53, 24, 4'b0010,  2, 1'b0);
    add( 64, 24, 4'b1010, 12, 1'b0);
    add( 64, 27, 4'b1010, 12, 1'b1);
    add( 65,  0, 4'b1010,  1, 1'b1);
    add( 65, 24, 4'b0000,  1, 1'b1);
    add( 76, 47, 4'b0000, 12, 1'b1);
    add( 77,  0, 4'b0000,  1, 1'b0);
    add( 77, 24, 4'b0100,  1, 1'b0);
    add( 88, 47, 4'b0100, 12, 1'b1);
    add( 89,  0, 4'b0100,  1, 1'b1);
    add( 89, 24, 4'b0000,  1, 1'b1);
    add(100, 47, 4'b0000, 12, 1'b1);
    add(101,  0, 4'b0000,  1, 1'b0);

    // Reset held for over 5 us with CLOCK running.
    wait_cyc(100);
    check("reset_idle", 0, 1'b1);
    wait_cyc(REL_CYC);
    check("reset_end", 0, 1'b1);
    SIM_RST_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      wait_cyc(T0 + SLOT * vecs[i].slot + vecs[i].ofs);
      check($sformatf("vec%0d_slot%0d", i, vecs[i].slot), vecs[i].exp_tp, vecs[i].exp_jam);
      {MSTRT, STRT2, MSTP, SBY} = vecs[i].ctl;
    end

    // Standby raised mid-T07; ring stops once SBY is through the synchronizer.
    a = T0 + SLOT * 107 + 24;
    wait_cyc(a);
    check("sby_pre", 7, 1'b0);
    SBY = 1'b1;
    wait_cyc(a + 2);
    check("sby_sync", 7, 1'b0);
    wait_cyc(a + 3);
    check("sby_stop", 0, 1'b1);

    // Drop SBY on a CLOCK-phase-aligned cycle: two ticks later T01 starts.
    b = ((a / 24) + 3) * 24;
    wait_cyc(b);
    check("sby_hold", 0, 1'b1);
    SBY = 1'b0;
    wait_cyc(b + 38);
    check("sby_wait", 0, 1'b1);
    wait_cyc(b + 39);
    check("sby_t01", 1, 1'b1);
    wait_cyc(b + 614);
    check("sby_t12", 12, 1'b1);
    wait_cyc(b + 615);
    check("sby_gojam_clr", 1, 1'b0);

    // Asynchronous reset in the middle of T09.
    c = b + 1023;
    wait_cyc(c);
    check("pre_rst_t09", 9, 1'b0);
    SIM_RST_n = 1'b0;
    #2;
    check("async_rst", 0, 1'b1);
    wait_cyc(c + 5);
    check("rst_hold", 0, 1'b1);
    SIM_RST_n = 1'b1;
    wait_cyc(c + 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
